scan_decoder: RTL and testbench

//  Parametrised registered N-to-2^N decoder with active-low (or active-high) one-hot select outputs.
//  Two modes:
//   - Manual: decodes addr_in.
//   - Auto-scan: a built-in prescaled counter steps through CH_NUM channels.

---
 rtl/scan_dec_pkg.sv | 23 ++
 rtl/scan_tick_gen.sv | 36 +++
 rtl/scan_decoder.sv | 125 ++++++++++++
 tb/tb_scan_decoder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/scan_dec_pkg.sv
// Shared types and helpers for the scan decoder: FSM state encoding and
// polarity-aware one-hot select generation.
package scan_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam int MAX_ADDR_W = 8;
  localparam int MAX_OUT    = 2 ** MAX_ADDR_W;

  // Full-width one-hot; callers size-cast down to their own output count.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr,
                                                input logic                  active_low);
    logic [MAX_OUT-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return active_low ? ~v : v;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts 0..PRESCALE-1 while run is high and pulses tick on
// the last count of each slot; clr forces the count back to zero.
module scan_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] CNT_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && !clr && (cnt_q == CNT_MAX);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N select decoder with manual addressing or a prescaled
// auto-scan over CH_NUM channels, with optional blanking at each slot start.
module scan_decoder
  import scan_dec_pkg::*;
#(
  parameter int ADDR_W     = 3,
  parameter int CH_NUM     = 8,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        addr_in,
  output logic [(2**ADDR_W)-1:0]   sel,
  output logic [ADDR_W-1:0]        cur_addr,
  output logic                     wrap
);

  localparam int                N_OUT      = 2 ** ADDR_W;
  localparam int                BW         = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
  localparam logic [BW-1:0]     BLANK_LAST = BW'(BLANK - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CH_NUM - 1);
  localparam logic [ADDR_W:0]   CH_LIM     = (ADDR_W + 1)'(CH_NUM);
  localparam logic [N_OUT-1:0]  SEL_OFF    = (ACTIVE_LOW != 0) ? '1 : '0;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [N_OUT-1:0]    sel_q, sel_d;
  logic                wrap_q, wrap_d;
  logic [BW-1:0]       blank_q, blank_d;
  logic                auto_q, auto_d;
  logic                tick;
  logic                run;

  // The prescaler only runs once auto mode has been active for a full cycle,
  // so every fresh auto entry (from reset, disable or manual) starts a clean slot.
  assign run = en && mode && auto_q;

  scan_tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (!run),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    blank_d    = blank_q;
    wrap_d     = 1'b0;
    auto_d     = en && mode;

    if (!en) begin
      state_d = ST_IDLE;
      blank_d = '0;
    end else if (!mode) begin
      state_d    = ST_SHOW;
      cur_addr_d = addr_in;
      blank_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          blank_d = '0;
        end
        ST_SHOW, ST_BLANK: begin
          if (state_q == ST_BLANK) begin
            if (blank_q == BLANK_LAST) begin
              state_d = ST_SHOW;
              blank_d = '0;
            end else begin
              blank_d = blank_q + BW'(1);
            end
          end
          if (tick) begin
            // Out-of-range addresses left over from manual mode also wrap to 0.
            wrap_d     = (cur_addr_q >= LAST_ADDR);
            cur_addr_d = wrap_d ? '0 : cur_addr_q + ADDR_W'(1);
            state_d    = (BLANK > 0) ? ST_BLANK : ST_SHOW;
            blank_d    = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          blank_d = '0;
        end
      endcase
    end

    if ((state_d == ST_SHOW) && ({1'b0, cur_addr_d} < CH_LIM)) begin
      sel_d = N_OUT'(onehot(MAX_ADDR_W'(cur_addr_d), ACTIVE_LOW != 0));
    end else begin
      sel_d = SEL_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      sel_q      <= SEL_OFF;
      wrap_q     <= 1'b0;
      blank_q    <= '0;
      auto_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      sel_q      <= sel_d;
      wrap_q     <= wrap_d;
      blank_q    <= blank_d;
      auto_q     <= auto_d;
    end
  end

  assign sel      = sel_q;
  assign cur_addr = cur_addr_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: two instances (active-low with blanking, active-high
// without) driven by the same directed and random stimulus, checked against a slot model.
module tb_scan_decoder;

  localparam int CH = 6;
  localparam int PS = 4;

  logic       clk = 1'b0;
  logic       rst_n, en, mode;
  logic [2:0] addr_in;
  logic [7:0] sel_a, sel_b;
  logic [2:0] ca_a, ca_b;
  logic       wr_a, wr_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  scan_decoder #(.ADDR_W(3), .CH_NUM(CH), .PRESCALE(PS), .BLANK(1), .ACTIVE_LOW(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr_in(addr_in),
    .sel(sel_a), .cur_addr(ca_a), .wrap(wr_a)
  );

  scan_decoder #(.ADDR_W(3), .CH_NUM(CH), .PRESCALE(PS), .BLANK(0), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr_in(addr_in),
    .sel(sel_b), .cur_addr(ca_b), .wrap(wr_b)
  );

  always #5 clk = ~clk;

  // Reference model: slot phase within the current slot plus a "fresh slot"
  // flag (first slot after entering auto mode is never blanked).
  int         m_addr[2];
  int         m_phase[2];
  bit         m_fresh[2];
  bit         m_prev_auto[2];
  bit         m_wrap[2];
  logic [7:0] m_sel[2];
  int         blank_of[2] = '{1, 0};
  bit         al_of[2]    = '{1'b1, 1'b0};

  logic [7:0] exp_a3[6] = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD};
  logic [7:0] exp_b3[6] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};

  function automatic logic [7:0] show(int k, int a);
    logic [7:0] v;
    v = (a < CH) ? 8'(1 << a) : 8'h00;
    return al_of[k] ? ~v : v;
  endfunction

  task automatic model_step(int k);
    m_wrap[k] = 1'b0;
    if (!rst_n) begin
      m_addr[k]      = 0;
      m_prev_auto[k] = 1'b0;
      m_sel[k]       = show(k, CH);
    end else if (!en) begin
      m_prev_auto[k] = 1'b0;
      m_sel[k]       = show(k, CH);
    end else if (!mode) begin
      m_addr[k]      = int'(addr_in);
      m_prev_auto[k] = 1'b0;
      m_sel[k]       = show(k, m_addr[k]);
    end else begin
      if (!m_prev_auto[k]) begin
        m_phase[k] = 0;
        m_fresh[k] = 1'b1;
      end else begin
        m_phase[k]++;
        if (m_phase[k] == PS) begin
          m_phase[k] = 0;
          m_fresh[k] = 1'b0;
          if (m_addr[k] >= CH - 1) begin
            m_addr[k] = 0;
            m_wrap[k] = 1'b1;
          end else begin
            m_addr[k]++;
          end
        end
      end
      m_prev_auto[k] = 1'b1;
      m_sel[k] = (!m_fresh[k] && m_phase[k] < blank_of[k]) ? show(k, CH) : show(k, m_addr[k]);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    cyc++;
    @(negedge clk);
    chk("model_sel_a",  32'(sel_a), 32'(m_sel[0]));
    chk("model_addr_a", 32'(ca_a),  32'(m_addr[0]));
    chk("model_wrap_a", 32'(wr_a),  32'(m_wrap[0]));
    chk("model_sel_b",  32'(sel_b), 32'(m_sel[1]));
    chk("model_addr_b", 32'(ca_b),  32'(m_addr[1]));
    chk("model_wrap_b", 32'(wr_b),  32'(m_wrap[1]));
  endtask

  int         first_w, second_w, wrap_addr, held;
  bit         hi_sel_bad, found;
  logic [7:0] e;

  initial begin
    rst_n   = 1'b0;
    en      = 1'($urandom);
    mode    = 1'($urandom);
    addr_in = 3'($urandom);
    step();
    step();
    chk("rst_sel_a", 32'(sel_a), 32'hFF);
    chk("rst_sel_b", 32'(sel_b), 32'h00);
    chk("rst_addr",  32'(ca_a),  32'd0);
    chk("rst_wrap",  32'(wr_a),  32'd0);

    rst_n   = 1'b1;
    en      = 1'b1;
    mode    = 1'b0;
    addr_in = 3'd3;
    step();
    chk("man3_sel_a", 32'(sel_a), 32'hF7);
    chk("man3_sel_b", 32'(sel_b), 32'h08);
    addr_in = 3'd7;
    step();
    chk("man7_sel_a", 32'(sel_a), 32'hFF);
    chk("man7_addr",  32'(ca_a),  32'd7);
    chk("man7_wrap",  32'(wr_a),  32'd0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mode  = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("auto_seq_a", 32'(sel_a), 32'(exp_a3[i]));
      chk("auto_seq_b", 32'(sel_b), 32'(exp_b3[i]));
    end

    first_w    = -1;
    second_w   = -1;
    wrap_addr  = 99;
    hi_sel_bad = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (sel_a[7:6] !== 2'b11) hi_sel_bad = 1'b1;
      if (wr_a === 1'b1) begin
        if (first_w < 0) begin
          first_w   = cyc;
          wrap_addr = int'(ca_a);
        end else if (second_w < 0) begin
          second_w = cyc;
        end
      end
    end
    chk("wrap_addr",   32'(wrap_addr),          32'd0);
    chk("scan_period", 32'(second_w - first_w), 32'd24);
    chk("no_sel_6_7",  32'(hi_sel_bad),         32'd0);

    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (m_phase[0] == 2 && m_prev_auto[0]) found = 1'b1;
      else step();
    end
    chk("find_phase2", 32'(found), 32'd1);
    held = m_addr[0];
    en   = 1'b0;
    step();
    chk("dis_sel",  32'(sel_a), 32'hFF);
    chk("dis_addr", 32'(ca_a),  32'(held));
    en = 1'b1;
    e  = ~(8'd1 << held);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("reen_show", 32'(sel_a), 32'(e));
    end
    step();
    chk("reen_blank", 32'(sel_a), 32'hFF);

    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      addr_in = 3'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
